// File: rtl/phy_rx_serial_to_parallel.sv
// Receive-side deserializer for one PHY lane: aligns on the comma symbol and emits bytes once locked.
// Defining PHY_RX_LOCK_LOSS_EN drops lock after MAX_RUN consecutive non-comma bytes in ACTIVE.
module phy_rx_serial_to_parallel #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_RUN    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    if (WIDTH < 2 || LOCK_COUNT < 1 || LOCK_COUNT > 15 || MAX_RUN < 1) begin : g_bad_param
        $error("phy_rx_serial_to_parallel: parameter out of range");
    end

    // Only WIDTH-1 bits of history are needed; the newest bit comes straight from data_in.
    logic [WIDTH-2:0] shift_reg, shift_reg_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]       comma_cnt, comma_cnt_n;
    state_t           state, state_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n, active_n;
    logic [WIDTH-1:0] cand;
    logic             boundary;

`ifdef PHY_RX_LOCK_LOSS_EN
    localparam int RUN_W = $clog2(MAX_RUN + 1);
    logic [RUN_W-1:0] run_cnt, run_cnt_n;
`endif

    always_comb begin
        cand        = {shift_reg, data_in};
        boundary    = (bit_cnt == CNT_W'(WIDTH - 1));
        shift_reg_n = cand[WIDTH-2:0];
        bit_cnt_n   = boundary ? '0 : bit_cnt + CNT_W'(1);
        comma_cnt_n = comma_cnt;
        state_n     = state;
        data_n      = data_out;
        valid_n     = valid_out;
        active_n    = active;
`ifdef PHY_RX_LOCK_LOSS_EN
        run_cnt_n   = run_cnt;
`endif

        case (state)
            SEARCH: begin
                // Any bit position may start a byte until a comma is seen.
                bit_cnt_n = '0;
                if (cand == COMMA) begin
                    comma_cnt_n = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        state_n  = ACTIVE;
                        active_n = 1'b1;
                    end else begin
                        state_n = LOCKING;
                    end
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (cand == COMMA) begin
                        comma_cnt_n = comma_cnt + 4'd1;
                        if (comma_cnt_n == 4'(LOCK_COUNT)) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        state_n     = SEARCH;
                        comma_cnt_n = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (cand != COMMA) begin
`ifdef PHY_RX_LOCK_LOSS_EN
                        // A run this long means the link lost alignment; drop the byte and resync.
                        if (run_cnt == RUN_W'(MAX_RUN - 1)) begin
                            state_n     = SEARCH;
                            active_n    = 1'b0;
                            valid_n     = 1'b0;
                            comma_cnt_n = '0;
                            run_cnt_n   = '0;
                        end else begin
                            run_cnt_n = run_cnt + RUN_W'(1);
                            data_n    = cand;
                            valid_n   = 1'b1;
                        end
`else
                        data_n  = cand;
                        valid_n = 1'b1;
`endif
                    end else begin
                        valid_n = 1'b0;
`ifdef PHY_RX_LOCK_LOSS_EN
                        run_cnt_n = '0;
`endif
                    end
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            state     <= SEARCH;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef PHY_RX_LOCK_LOSS_EN
            run_cnt   <= '0;
`endif
        end else begin
            shift_reg <= shift_reg_n;
            bit_cnt   <= bit_cnt_n;
            comma_cnt <= comma_cnt_n;
            state     <= state_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= active_n;
`ifdef PHY_RX_LOCK_LOSS_EN
            run_cnt   <= run_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// Directed bench for phy_rx_serial_to_parallel: alignment, lock, data emission, relock and the long-run rule.
module tb_phy_rx_serial_to_parallel;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int tests_run;
    int tests_failed;

    phy_rx_serial_to_parallel #(
        .WIDTH(8),
        .COMMA(8'hBC),
        .LOCK_COUNT(4),
        .MAX_RUN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift a byte in MSB first; returns #1 after the edge that completes it.
    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            tick();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_data,
                               input logic exp_valid, input logic exp_active);
        tests_run++;
        assert (data_out === exp_data) else begin
            tests_failed++;
            $error("[TB] FAIL %s data_out observed %h expected %h", tag, data_out, exp_data);
        end
        tests_run++;
        assert (valid_out === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL %s valid_out observed %b expected %b", tag, valid_out, exp_valid);
        end
        tests_run++;
        assert (active === exp_active) else begin
            tests_failed++;
            $error("[TB] FAIL %s active observed %b expected %b", tag, active, exp_active);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        data_in      = 1'b0;

        // Reset state, then idle zeros never lock
        repeat (3) tick();
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (20) tick();
        checkOutput("idle_zero", 8'h00, 1'b0, 1'b0);

        // Misaligned start, four commas, then data
        data_in = 1'($urandom_range(0, 1));
        tick();
        applyStimulus(8'hBC);
        checkOutput("comma1", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        checkOutput("comma3", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("lock", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF);
        checkOutput("data_ff", 8'hFF, 1'b1, 1'b1);
        applyStimulus(8'hEE);
        checkOutput("data_ee", 8'hEE, 1'b1, 1'b1);

        // Comma between data holds data_out, straddling comma pattern does not realign
        applyStimulus(8'hBB);
        checkOutput("data_bb", 8'hBB, 1'b1, 1'b1);
        applyStimulus(8'hBC);
        checkOutput("idle_hold", 8'hBB, 1'b0, 1'b1);
        applyStimulus(8'hAA);
        checkOutput("data_aa", 8'hAA, 1'b1, 1'b1);
        applyStimulus(8'h0B);
        checkOutput("straddle_0b", 8'h0B, 1'b1, 1'b1);
        for (int i = 7; i >= 4; i--) begin
            data_in = 1'(8'hC0 >> i);
            tick();
        end
        checkOutput("mid_byte_stable", 8'h0B, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            data_in = 1'(8'hC0 >> i);
            tick();
        end
        checkOutput("straddle_c0", 8'hC0, 1'b1, 1'b1);

        // Broken lock sequence falls back to SEARCH
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset2", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        applyStimulus(8'h55);
        checkOutput("lock_abort", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        checkOutput("relock_3", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("relock_4", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h3C);
        checkOutput("data_3c", 8'h3C, 1'b1, 1'b1);

        // Reset mid-byte while ACTIVE
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        data_in = 1'b0; tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("reset_mid", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        applyStimulus(8'hBC);
        checkOutput("fresh_3", 8'h00, 1'b0, 1'b0);
        applyStimulus(8'hBC);
        checkOutput("fresh_4", 8'h00, 1'b0, 1'b1);

        // Long non-comma run with MAX_RUN = 4
        applyStimulus(8'h11);
        checkOutput("run1", 8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22);
        checkOutput("run2", 8'h22, 1'b1, 1'b1);
        applyStimulus(8'h33);
        checkOutput("run3", 8'h33, 1'b1, 1'b1);
        applyStimulus(8'h44);
`ifdef PHY_RX_LOCK_LOSS_EN
        checkOutput("run4", 8'h33, 1'b0, 1'b0);
        applyStimulus(8'h66);
        checkOutput("run5", 8'h33, 1'b0, 1'b0);
`else
        checkOutput("run4", 8'h44, 1'b1, 1'b1);
        applyStimulus(8'h66);
        checkOutput("run5", 8'h66, 1'b1, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
